// File: rtl/axi_lite_regbank.sv
// AXI4-Lite control/status slave: NUM_RW byte-strobed configuration registers followed by
// NUM_RO read-only status words; RO writes and out-of-range accesses answer SLVERR.
module axi_lite_regbank #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int NUM_RW     = 4,
    parameter int NUM_RO     = 2
) (
    input  logic                         ACLK,
    input  logic                         ARESET,
    input  logic [ADDR_WIDTH-1:0]        S_AXI_AWADDR,
    input  logic [2:0]                   S_AXI_AWPROT,
    input  logic                         S_AXI_AWVALID,
    output logic                         S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]        S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]      S_AXI_WSTRB,
    input  logic                         S_AXI_WVALID,
    output logic                         S_AXI_WREADY,
    output logic [1:0]                   S_AXI_BRESP,
    output logic                         S_AXI_BVALID,
    input  logic                         S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]        S_AXI_ARADDR,
    input  logic [2:0]                   S_AXI_ARPROT,
    input  logic                         S_AXI_ARVALID,
    output logic                         S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]        S_AXI_RDATA,
    output logic [1:0]                   S_AXI_RRESP,
    output logic                         S_AXI_RVALID,
    input  logic                         S_AXI_RREADY,
    output logic [NUM_RW*DATA_WIDTH-1:0] reg_out,
    input  logic [NUM_RO*DATA_WIDTH-1:0] status_in,
    output logic [NUM_RW-1:0]            wr_pulse
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int IDX_W  = ADDR_WIDTH - LSB;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} wstate_e;
    typedef enum logic {R_IDLE, R_DATA} rstate_e;

    wstate_e                wstate_q, wstate_d;
    rstate_e                rstate_q, rstate_d;
    logic                   awready_q, awready_d, wready_q, wready_d;
    logic                   aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [IDX_W-1:0]       awidx_q, awidx_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [STRB_W-1:0]      wstrb_q, wstrb_d;
    logic                   bvalid_q, bvalid_d;
    logic [1:0]             bresp_q, bresp_d;
    logic                   arready_q, arready_d, rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic [1:0]             rresp_q, rresp_d;
    logic [NUM_RW-1:0]      wr_pulse_q, wr_pulse_d;
    logic [DATA_WIDTH-1:0]  regs_q [NUM_RW];
    logic [DATA_WIDTH-1:0]  regs_d [NUM_RW];
    int                     widx, ridx;

    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[LSB-1:0], S_AXI_ARADDR[LSB-1:0]};

    function automatic int idx_of(input logic [IDX_W-1:0] a);
        return int'(a);
    endfunction

    // Write channel: AW and W are latched independently; commit on the edge both are held.
    always_comb begin
        wstate_d   = wstate_q;
        awready_d  = awready_q;
        wready_d   = wready_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        awidx_d    = awidx_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        wr_pulse_d = '0;
        regs_d     = regs_q;
        widx       = 0;
        if (wstate_q == W_IDLE) begin
            if (S_AXI_AWVALID && awready_q) begin
                aw_held_d = 1'b1;
                awidx_d   = S_AXI_AWADDR[ADDR_WIDTH-1:LSB];
            end
            if (S_AXI_WVALID && wready_q) begin
                w_held_d = 1'b1;
                wdata_d  = S_AXI_WDATA;
                wstrb_d  = S_AXI_WSTRB;
            end
            awready_d = !aw_held_d;
            wready_d  = !w_held_d;
            if (aw_held_d && w_held_d) begin
                widx      = idx_of(awidx_d);
                aw_held_d = 1'b0;
                w_held_d  = 1'b0;
                awready_d = 1'b0;
                wready_d  = 1'b0;
                bvalid_d  = 1'b1;
                wstate_d  = W_RESP;
                bresp_d   = (widx < NUM_RW) ? RESP_OKAY : RESP_SLVERR;
                for (int k = 0; k < NUM_RW; k++) begin
                    if (widx == k) begin
                        wr_pulse_d[k] = 1'b1;
                        for (int b = 0; b < STRB_W; b++) begin
                            if (wstrb_d[b]) regs_d[k][8*b +: 8] = wdata_d[8*b +: 8];
                        end
                    end
                end
            end
        end else if (S_AXI_BREADY) begin
            bvalid_d  = 1'b0;
            awready_d = 1'b1;
            wready_d  = 1'b1;
            wstate_d  = W_IDLE;
        end
    end

    // Read channel: reads the pre-update register image, so a same-edge write is not visible.
    always_comb begin
        rstate_d  = rstate_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        ridx      = 0;
        if (rstate_q == R_IDLE) begin
            arready_d = 1'b1;
            if (S_AXI_ARVALID && arready_q) begin
                ridx      = idx_of(S_AXI_ARADDR[ADDR_WIDTH-1:LSB]);
                arready_d = 1'b0;
                rvalid_d  = 1'b1;
                rstate_d  = R_DATA;
                rdata_d   = '0;
                rresp_d   = RESP_SLVERR;
                for (int k = 0; k < NUM_RW; k++) begin
                    if (ridx == k) begin
                        rdata_d = regs_q[k];
                        rresp_d = RESP_OKAY;
                    end
                end
                for (int k = 0; k < NUM_RO; k++) begin
                    if (ridx == NUM_RW + k) begin
                        rdata_d = status_in[k*DATA_WIDTH +: DATA_WIDTH];
                        rresp_d = RESP_OKAY;
                    end
                end
            end
        end else if (S_AXI_RREADY) begin
            rvalid_d  = 1'b0;
            arready_d = 1'b1;
            rstate_d  = R_IDLE;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wstate_q   <= W_IDLE;
            rstate_q   <= R_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awidx_q    <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= '0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= '0;
            wr_pulse_q <= '0;
            for (int k = 0; k < NUM_RW; k++) regs_q[k] <= '0;
        end else begin
            wstate_q   <= wstate_d;
            rstate_q   <= rstate_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            awidx_q    <= awidx_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            wr_pulse_q <= wr_pulse_d;
            for (int k = 0; k < NUM_RW; k++) regs_q[k] <= regs_d[k];
        end
    end

    for (genvar g = 0; g < NUM_RW; g++) begin : g_reg_out
        assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign wr_pulse      = wr_pulse_q;
endmodule

// File: tb/tb_axi_lite_regbank.sv
// Directed bench for axi_lite_regbank: a transaction-level register model checked every
// cycle, plus literal expectations on read data, responses, latency and reset behaviour.
module tb_axi_lite_regbank;
    logic         ACLK = 1'b0;
    logic         ARESET;
    logic [5:0]   S_AXI_AWADDR, S_AXI_ARADDR;
    logic [2:0]   S_AXI_AWPROT, S_AXI_ARPROT;
    logic         S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
    logic [31:0]  S_AXI_WDATA, S_AXI_RDATA;
    logic [3:0]   S_AXI_WSTRB;
    logic [1:0]   S_AXI_BRESP, S_AXI_RRESP;
    logic         S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
    logic         S_AXI_RVALID, S_AXI_RREADY;
    logic [127:0] reg_out;
    logic [63:0]  status_in;
    logic [3:0]   wr_pulse;

    axi_lite_regbank #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .NUM_RW(4), .NUM_RO(2)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .reg_out(reg_out), .status_in(status_in), .wr_pulse(wr_pulse)
    );

    always #5 ACLK = ~ACLK;

    int vectors = 0;
    int errors  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Register model and the expectations it raises for the cycle after each edge.
    logic [31:0] mdl [4];
    logic        aw_p, w_p, commit_next, rd_next;
    logic [5:0]  aw_a;
    logic [31:0] w_d, exp_rd, hold_rd;
    logic [3:0]  w_s, exp_pulse;
    logic [1:0]  exp_b, hold_b, exp_rr, hold_rr;

    function automatic void model_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] r);
        if (a[5:2] < 4'd4) begin
            d = mdl[a[3:2]];
            r = 2'b00;
        end else if (a[5:2] < 4'd6) begin
            d = a[2] ? status_in[63:32] : status_in[31:0];
            r = 2'b00;
        end else begin
            d = 32'h0;
            r = 2'b10;
        end
    endfunction

    always @(negedge ACLK) begin
        if (ARESET) begin
            check("reset_outputs", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BRESP,
                  S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RRESP, S_AXI_RDATA, wr_pulse}, '0);
            check("reset_reg_out", reg_out, '0);
            for (int i = 0; i < 4; i++) mdl[i] = 32'h0;
            aw_p = 1'b0; w_p = 1'b0; commit_next = 1'b0; rd_next = 1'b0;
        end else begin
            if (commit_next) begin
                check("bvalid_rise", S_AXI_BVALID, 1'b1);
                check("bresp", S_AXI_BRESP, exp_b);
                check("wr_pulse", wr_pulse, exp_pulse);
                if (exp_b == 2'b00)
                    for (int b = 0; b < 4; b++)
                        if (w_s[b]) mdl[aw_a[3:2]][8*b +: 8] = w_d[8*b +: 8];
                hold_b = exp_b;
                commit_next = 1'b0;
            end else begin
                check("wr_pulse_idle", wr_pulse, 4'h0);
                if (S_AXI_BVALID) check("bresp_stable", S_AXI_BRESP, hold_b);
            end
            if (rd_next) begin
                check("rvalid_rise", S_AXI_RVALID, 1'b1);
                check("rdata", S_AXI_RDATA, exp_rd);
                check("rresp", S_AXI_RRESP, exp_rr);
                hold_rd = exp_rd; hold_rr = exp_rr;
                rd_next = 1'b0;
            end else if (S_AXI_RVALID) begin
                check("rdata_stable", {S_AXI_RRESP, S_AXI_RDATA}, {hold_rr, hold_rd});
            end
            check("reg_out", reg_out, {mdl[3], mdl[2], mdl[1], mdl[0]});
            if (S_AXI_BVALID) check("aw_w_blocked", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b00);
            if (S_AXI_RVALID) check("ar_blocked", S_AXI_ARREADY, 1'b0);
            if (S_AXI_ARVALID && S_AXI_ARREADY) begin
                model_read(S_AXI_ARADDR, exp_rd, exp_rr);
                rd_next = 1'b1;
            end
            if (S_AXI_AWVALID && S_AXI_AWREADY) begin aw_p = 1'b1; aw_a = S_AXI_AWADDR; end
            if (S_AXI_WVALID && S_AXI_WREADY) begin w_p = 1'b1; w_d = S_AXI_WDATA; w_s = S_AXI_WSTRB; end
            if (aw_p && w_p) begin
                commit_next = 1'b1;
                exp_b     = (aw_a[5:2] < 4'd4) ? 2'b00 : 2'b10;
                exp_pulse = (aw_a[5:2] < 4'd4) ? (4'b0001 << aw_a[3:2]) : 4'h0;
                aw_p = 1'b0; w_p = 1'b0;
            end
        end
    end

    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input int b_hold, input logic [1:0] exp_resp);
        bit aw_done = 0, w_done = 0, hs_aw, hs_w;
        int cyc = 0;
        S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
        while (!(aw_done && w_done) && cyc < 40) begin
            S_AXI_AWVALID = !aw_done && (cyc >= aw_dly);
            S_AXI_WVALID  = !w_done && (cyc >= w_dly);
            @(negedge ACLK);
            if (aw_done ^ w_done) begin
                check("awready_after_hs", S_AXI_AWREADY, !aw_done);
                check("wready_after_hs", S_AXI_WREADY, !w_done);
                check("bvalid_early", S_AXI_BVALID, 1'b0);
            end
            hs_aw = S_AXI_AWVALID && S_AXI_AWREADY;
            hs_w  = S_AXI_WVALID && S_AXI_WREADY;
            @(posedge ACLK); #1;
            aw_done |= hs_aw; w_done |= hs_w; cyc++;
        end
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        if (!(aw_done && w_done)) check("write_handshake_timeout", {aw_done, w_done}, 2'b11);
        @(negedge ACLK);
        check("b_latency", S_AXI_BVALID, 1'b1);
        check("b_resp_lit", S_AXI_BRESP, exp_resp);
        repeat (b_hold) @(negedge ACLK);
        @(posedge ACLK); #1; S_AXI_BREADY = 1'b1;
        @(posedge ACLK); #1; S_AXI_BREADY = 1'b0;
        check("b_done", S_AXI_BVALID, 1'b0);
    endtask

    task automatic axi_read(input logic [5:0] a, input logic [31:0] exp_d, input logic [1:0] exp_r, input int r_hold);
        bit done = 0, hs;
        int cyc = 0;
        S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
        while (!done && cyc < 40) begin
            @(negedge ACLK);
            hs = S_AXI_ARVALID && S_AXI_ARREADY;
            @(posedge ACLK); #1;
            done = hs; cyc++;
        end
        S_AXI_ARVALID = 1'b0;
        if (!done) check("read_handshake_timeout", done, 1'b1);
        @(negedge ACLK);
        check("r_latency", S_AXI_RVALID, 1'b1);
        check("rdata_lit", S_AXI_RDATA, exp_d);
        check("rresp_lit", S_AXI_RRESP, exp_r);
        repeat (r_hold) @(negedge ACLK);
        @(posedge ACLK); #1; S_AXI_RREADY = 1'b1;
        @(posedge ACLK); #1; S_AXI_RREADY = 1'b0;
        check("r_done", S_AXI_RVALID, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1);
    end

    initial begin
        ARESET = 1'b1;
        S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
        S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
        status_in = {32'h0000CAFE, 32'h12345678};
        repeat (3) @(posedge ACLK);
        #1 ARESET = 1'b0;
        @(posedge ACLK); #1;
        check("ready_after_reset", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);

        // Full-word writes and readback
        for (int i = 0; i < 4; i++) axi_write(6'(i * 4), 32'(i + 1), 4'hF, 0, 0, 0, 2'b00);
        for (int i = 0; i < 4; i++) axi_read(6'(i * 4), 32'(i + 1), 2'b00, 0);

        // Byte-lane merge
        axi_write(6'h04, 32'hAABBCCDD, 4'hF, 0, 0, 0, 2'b00);
        axi_write(6'h04, 32'h11223344, 4'h5, 0, 0, 0, 2'b00);
        axi_read(6'h04, 32'hAA22CC44, 2'b00, 0);
        check("reg_out_reg1_lit", reg_out[63:32], 32'hAA22CC44);
        axi_write(6'h05, 32'h00000000, 4'h0, 0, 0, 0, 2'b00);
        check("strb0_no_change", reg_out[63:32], 32'hAA22CC44);

        // Independent AW/W ordering
        axi_write(6'h08, 32'hDEADBEEF, 4'hF, 0, 3, 0, 2'b00);
        axi_read(6'h08, 32'hDEADBEEF, 2'b00, 0);
        axi_write(6'h08, 32'h00000000, 4'hF, 0, 0, 0, 2'b00);
        axi_write(6'h0B, 32'hDEADBEEF, 4'hF, 3, 0, 0, 2'b00);
        axi_read(6'h08, 32'hDEADBEEF, 2'b00, 0);

        // Status window and illegal accesses
        axi_read(6'h10, 32'h12345678, 2'b00, 0);
        axi_read(6'h14, 32'h0000CAFE, 2'b00, 0);
        axi_write(6'h10, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 2'b10);
        axi_write(6'h3C, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 2'b10);
        axi_read(6'h18, 32'h0, 2'b10, 0);
        axi_read(6'h3F, 32'h0, 2'b10, 0);

        // Back-pressure on both response channels
        axi_write(6'h0C, 32'h00000077, 4'hF, 0, 0, 5, 2'b00);
        axi_read(6'h0C, 32'h00000077, 2'b00, 5);

        // Same-edge write and read of reg2: the read sees the old value
        S_AXI_AWADDR = 6'h08; S_AXI_WDATA = 32'h55; S_AXI_WSTRB = 4'hF; S_AXI_ARADDR = 6'h08;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        @(negedge ACLK);
        check("same_edge_old_value", S_AXI_RDATA, 32'hDEADBEEF);
        check("same_edge_bvalid", {S_AXI_BVALID, S_AXI_RVALID}, 2'b11);
        @(posedge ACLK); #1; S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
        @(posedge ACLK); #1; S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
        axi_read(6'h08, 32'h00000055, 2'b00, 0);

        // Reset with both a write response and a read response pending
        S_AXI_AWADDR = 6'h04; S_AXI_WDATA = 32'h12; S_AXI_WSTRB = 4'hF; S_AXI_ARADDR = 6'h00;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        @(negedge ACLK);
        check("pre_reset_valids", {S_AXI_BVALID, S_AXI_RVALID}, 2'b11);
        @(posedge ACLK); #1; ARESET = 1'b1; #1;
        check("reset_valids_drop", {S_AXI_BVALID, S_AXI_RVALID}, 2'b00);
        check("reset_regs_cleared", reg_out, '0);
        @(posedge ACLK); #1; ARESET = 1'b0;
        @(posedge ACLK); #1;
        check("ready_after_rerelease", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
        axi_write(6'h00, 32'hCAFEF00D, 4'hF, 0, 0, 0, 2'b00);
        axi_read(6'h00, 32'hCAFEF00D, 2'b00, 0);
        axi_read(6'h04, 32'h00000000, 2'b00, 0);

        repeat (2) @(negedge ACLK);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
